pingpong_reader: RTL and testbench

PINGPONG_READER -- requirements
Module: pingpong_reader

---
 rtl/pingpong_reader_pkg.sv | 14 +
 rtl/pingpong_skid_fifo.sv | 52 +++++
 rtl/pingpong_reader.sv | 123 ++++++++++++
 tb/tb_pingpong_reader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_reader_pkg.sv
// Shared types for the ping-pong buffer blocks:
// FSM state encoding and default geometry.
package pingpong_reader_pkg;

  localparam int unsigned PP_HALF_DEPTH = 256;
  localparam int unsigned PP_DW         = 8;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } pp_state_e;

endpackage

// File: rtl/pingpong_skid_fifo.sv
// Two-entry output FIFO with synchronous flush
// and an occupancy count for read throttling.
module pingpong_skid_fifo #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] din_i,
  input  logic          pop_i,
  output logic [DW-1:0] dout_o,
  output logic [1:0]    count_o
);

  logic [DW-1:0] mem_q [2];
  logic          wp_q;
  logic          rp_q;
  logic [1:0]    cnt_q;
  logic          do_push;
  logic          do_pop;

  assign do_push = push_i && (cnt_q != 2'd2);
  assign do_pop  = pop_i && (cnt_q != 2'd0);
  assign dout_o  = mem_q[rp_q];
  assign count_o = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wp_q     <= 1'b0;
      rp_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else if (flush_i) begin
      wp_q  <= 1'b0;
      rp_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= din_i;
        wp_q        <= ~wp_q;
      end
      if (do_pop) begin
        rp_q <= ~rp_q;
      end
      cnt_q <= cnt_q + {1'b0, do_push}
                     - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/pingpong_reader.sv
// Read side of a ping-pong buffer: streams one
// latched half of shared memory out over valid/ready.
module pingpong_reader
  import pingpong_reader_pkg::*;
#(
  parameter  int HALF_DEPTH = PP_HALF_DEPTH,
  parameter  int DW         = PP_DW,
  localparam int CW         = $clog2(HALF_DEPTH),
  localparam int AW         = CW + 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          read_mode,
  input  logic          read_ptr,
  output logic          read_done,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy
);

  pp_state_e   state_q, state_d;
  logic        half_q, half_d;
  logic [CW:0] rd_cnt_q;
  logic [CW-1:0] tx_cnt_q;
  logic        inflight_q;
  logic [1:0]  fifo_cnt;
  logic [2:0]  occ;
  logic        xfer;
  logic        flush;
  logic        push;

  assign out_valid = (fifo_cnt != 2'd0);
  assign xfer      = out_valid && out_ready;
  assign out_last  = out_valid
                  && (tx_cnt_q == CW'(HALF_DEPTH - 1));
  assign mem_addr  = {half_q, rd_cnt_q[CW-1:0]};

  // Credit the slot freed by this cycle's pop so
  // a held-high out_ready sustains one byte/cycle.
  assign occ = {1'b0, fifo_cnt}
             + {2'b0, inflight_q}
             - {2'b0, xfer};

  assign mem_rd_en = (state_q == STREAM)
                  && read_mode
                  && !rd_cnt_q[CW]
                  && (occ < 3'd2);

  assign flush = (state_d != STREAM);
  assign push  = inflight_q && !flush;

  always_comb begin
    state_d   = state_q;
    half_d    = half_q;
    read_done = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read_mode) begin
          state_d = STREAM;
          half_d  = read_ptr;
        end
      end
      STREAM: begin
        busy = 1'b1;
        if (!read_mode) begin
          state_d = IDLE;
        end else if (xfer && out_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        read_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      half_q     <= 1'b0;
      rd_cnt_q   <= '0;
      tx_cnt_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q <= state_d;
      half_q  <= half_d;
      if (flush) begin
        rd_cnt_q   <= '0;
        tx_cnt_q   <= '0;
        inflight_q <= 1'b0;
      end else begin
        rd_cnt_q   <= rd_cnt_q
                    + {{CW{1'b0}}, mem_rd_en};
        tx_cnt_q   <= tx_cnt_q
                    + {{(CW-1){1'b0}}, xfer};
        inflight_q <= mem_rd_en;
      end
    end
  end

  pingpong_skid_fifo #(
    .DW(DW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (reset_n),
    .flush_i(flush),
    .push_i (push),
    .din_i  (mem_rdata),
    .pop_i  (xfer),
    .dout_o (out_data),
    .count_o(fifo_cnt)
  );

endmodule

// File: tb/tb_pingpong_reader.sv
// Bench for pingpong_reader: vector table of passes
// checked against a byte scoreboard from a memory model.
module tb_pingpong_reader;

  localparam int HD = 256;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       read_mode = 1'b0;
  logic       read_ptr = 1'b0;
  logic       out_ready = 1'b0;
  logic       read_done;
  logic       mem_rd_en;
  logic [8:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_last;
  logic       busy;

  logic [7:0] mem [512];
  int n_chk = 0;
  int n_pass = 0;
  int swaps = 0;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic ptr;
    logic rnd;
    int   tog;
    int   abrt;
    int   rst;
    int   dones;
  } vec_t;
  vec_t vt[7];

  pingpong_reader dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .read_mode(read_mode),
    .read_ptr (read_ptr),
    .read_done(read_done),
    .mem_rd_en(mem_rd_en),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (mem_rd_en) mem_rdata <= mem[mem_addr];

  always @(negedge clk)
    if (read_done === 1'b1) swaps++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic fill_half(input logic h);
    for (int k = 0; k < HD; k++)
      mem[{h, 8'(k)}] = 8'($urandom);
  endtask

  task automatic zero_outs(input string tag);
    chk({tag, "_done"}, read_done, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_rden"}, mem_rd_en, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, out_data, 0);
  endtask

  task automatic run_pass(input vec_t v);
    int   tx = 0;
    int   cyc = 0;
    int   dones = 0;
    int   fv = -1;
    int   t0 = -1;
    int   t1 = -1;
    int   tdone = -1;
    bit   hv = 0;
    bit   tog_done = 0;
    bit   stop = 0;
    logic [7:0] held = '0;
    exp_t e;
    exp_q.delete();
    for (int k = 0; k < HD; k++)
      exp_q.push_back('{d: mem[{v.ptr, 8'(k)}],
                        l: (k == HD - 1)});
    @(posedge clk); #1;
    read_ptr  = v.ptr;
    read_mode = 1'b1;
    out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    while (!stop && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (out_valid && fv < 0) fv = cyc;
      if (hv && out_valid) chk("hold_data", out_data, held);
      hv   = out_valid && !out_ready;
      held = out_data;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_byte", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data", out_data, e.d);
          chk("last", out_last, e.l);
        end
        if (t0 < 0) t0 = cyc;
        t1 = cyc;
        tx++;
      end
      if (read_done) begin
        dones++;
        tdone = cyc;
        stop  = 1;
      end
      @(posedge clk); #1;
      out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (stop) read_mode = 1'b0;
      if (v.tog >= 0 && tx >= v.tog && !tog_done) begin
        read_ptr = ~read_ptr;
        tog_done = 1;
      end
      if (v.abrt >= 0 && tx == v.abrt) begin
        read_mode = 1'b0;
        out_ready = 1'b0;
        stop      = 1;
      end
      if (v.rst >= 0 && tx == v.rst) begin
        read_mode = 1'b0;
        reset_n   = 1'b0;
        #1;
        zero_outs("midrst");
        stop = 1;
      end
    end
    if (cyc >= 3000) chk("timeout", 0, 1);
    if (v.abrt >= 0) begin
      @(negedge clk);
      chk("abort_done", read_done, 0);
      @(negedge clk);
      chk("abort_busy", busy, 0);
      chk("abort_valid", out_valid, 0);
    end
    if (v.rst >= 0) begin
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
    end
    repeat (4) begin
      @(negedge clk);
      if (read_done) dones++;
    end
    chk("dones", dones, v.dones);
    chk("busy_end", busy, 0);
    if (v.abrt < 0 && v.rst < 0) begin
      chk("remaining", exp_q.size(), 0);
      chk("latency", fv, 4);
      chk("done_after_last", tdone, t1 + 1);
      if (!v.rnd) chk("burst", t1 - t0, HD - 1);
    end
  endtask

  initial begin
    int s0;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    vt[0] = '{1'b0, 1'b0, -1, -1, -1, 1};
    vt[1] = '{1'b1, 1'b1, -1, -1, -1, 1};
    vt[2] = '{1'b0, 1'b0, 100, -1, -1, 1};
    vt[3] = '{1'b1, 1'b0, -1, 40, -1, 0};
    vt[4] = '{1'b1, 1'b1, -1, -1, -1, 1};
    vt[5] = '{1'b0, 1'b0, -1, -1, 128, 0};
    vt[6] = '{1'b0, 1'b1, -1, -1, -1, 1};

    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    zero_outs("reset");
    reset_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) run_pass(vt[i]);

    s0 = swaps;
    fill_half(1'b0);
    run_pass('{1'b0, 1'b0, -1, -1, -1, 1});
    fill_half(1'b1);
    run_pass('{1'b1, 1'b1, -1, -1, -1, 1});
    chk("swap_count", swaps - s0, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
